// File: rtl/dsp_pipelined_adder_pkg.sv
// Shared constants and flag helpers for the DSP adder/subtractor family.
package dsp_pipelined_adder_pkg;

    localparam int DSP_WIDTH = 32;
    localparam int DSP_HALF  = DSP_WIDTH / 2;

    // Signed overflow of an add: both operands share a sign and the sum's sign differs.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/dsp_pipelined_adder_if.sv
// Valid/ready operand and result channels of the pipelined adder.
interface dsp_pipelined_adder_if
    import dsp_pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DSP_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             overflow;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, input1, input2, out_ready,
        input  in_ready, out_valid, out, carry_out, overflow
    );

    // The adder itself.
    modport slave (
        input  in_valid, input1, input2, out_ready,
        output in_ready, out_valid, out, carry_out, overflow
    );
endinterface

// File: rtl/dsp_add_slice.sv
// Half-width adder with carry in/out; maps to an SB_MAC16 in adder mode or a fabric carry chain.
module dsp_add_slice
    import dsp_pipelined_adder_pkg::*;
#(
    parameter int HALF = DSP_HALF
) (
    input  logic [HALF-1:0] a,
    input  logic [HALF-1:0] b,
    input  logic            cin,
    output logic [HALF-1:0] sum,
    output logic            cout
);
    // All terms are widened to HALF+1 bits so the carry lands in the top bit.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{HALF{1'b0}}, cin};
endmodule

// File: rtl/dsp_pipelined_adder.sv
// Two-stage pipelined adder: low half in stage 1, high half plus registered carry in stage 2.
module dsp_pipelined_adder
    import dsp_pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DSP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    dsp_pipelined_adder_if.slave  bus
);
    localparam int HALF = WIDTH / 2;

    // Stage 1 state: low-half sum, its carry, and the untouched high halves.
    logic            s1_valid;
    logic [HALF-1:0] s1_lo;
    logic            s1_c16;
    logic [HALF-1:0] s1_a_hi;
    logic [HALF-1:0] s1_b_hi;

    // Stage 2 state doubles as the registered output.
    logic             s2_valid;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             ovf_q;

    logic            s1_ready;
    logic            s2_ready;
    logic [HALF-1:0] lo_sum;
    logic            lo_carry;
    logic [HALF-1:0] hi_sum;
    logic            hi_carry;

    // Per-stage ready: a stage can take data if empty or if its contents leave this cycle.
    assign s2_ready     = !s2_valid || bus.out_ready;
    assign s1_ready     = !s1_valid || s2_ready;
    assign bus.in_ready = s1_ready;

    assign bus.out_valid = s2_valid;
    assign bus.out       = out_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;

    dsp_add_slice #(.HALF(HALF)) u_lo_slice (
        .a    (bus.input1[HALF-1:0]),
        .b    (bus.input2[HALF-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_carry)
    );

    dsp_add_slice #(.HALF(HALF)) u_hi_slice (
        .a    (s1_a_hi),
        .b    (s1_b_hi),
        .cin  (s1_c16),
        .sum  (hi_sum),
        .cout (hi_carry)
    );

    // Valid bits and output registers: reset clears them, each stage loads when ready.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            out_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_q   <= {hi_sum, s1_lo};
                    carry_q <= hi_carry;
                    // The operand sign bits are the top bits of the captured high halves.
                    ovf_q   <= ovf_flag(s1_a_hi[HALF-1], s1_b_hi[HALF-1], hi_sum[HALF-1]);
                end
            end
        end
    end

    // Stage 1 datapath: captures on input transfer.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are not reset; s1_valid already qualifies them, so reset stays off the wide bus.
        if (s1_ready && bus.in_valid) begin
            s1_lo   <= lo_sum;
            s1_c16  <= lo_carry;
            s1_a_hi <= bus.input1[WIDTH-1:HALF];
            s1_b_hi <= bus.input2[WIDTH-1:HALF];
        end
    end

endmodule

// File: tb/tb_dsp_pipelined_adder.sv
// Directed self-checking bench for the pipelined adder.
module tb_dsp_pipelined_adder;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic        v;
        int          cyc;
    } rx_t;

    rx_t rx_q[$];

    dsp_pipelined_adder_if #(.WIDTH(32)) bus ();

    dsp_pipelined_adder #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result transfer, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            rx_q.push_back('{d: bus.out, c: bus.carry_out, v: bus.overflow, cyc: cyc});
        end
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called just after a rising edge; returns the cycle in which the pair transferred.
    task automatic send(input logic [31:0] a, input logic [31:0] b, output int acc);
        bus.in_valid = 1'b1;
        bus.input1   = a;
        bus.input2   = b;
        acc          = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = cyc;
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 40 && rx_q.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        if (rx_q.size() < n) check("rx_timeout", rx_q.size(), n);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One isolated add with out_ready held high; checks value, flags and 2-cycle latency.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic exp_c, input logic exp_v);
        int  acc;
        rx_t r;
        rx_q.delete();
        send(a, b, acc);
        wait_rx(1);
        if (rx_q.size() >= 1) begin
            r = rx_q.pop_front();
            check({tag, "_out"},     r.d, exp_d);
            check({tag, "_carry"},   r.c, exp_c);
            check({tag, "_ovf"},     r.v, exp_v);
            check({tag, "_latency"}, r.cyc - acc, 2);
        end
    endtask

    initial begin
        int  acc;
        int  acc8[8];
        rx_t r;
        logic [31:0] exp4[4];

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.input1    = '0;
        bus.input2    = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out",       bus.out, 0);
        check("rst_carry",     bus.carry_out, 0);
        check("rst_ovf",       bus.overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Basic adds, mid carry, wrap-around and signed overflow.
        bus.out_ready = 1'b1;
        run_one("add_10_9",   32'd10,        32'd9,         32'd19,        1'b0, 1'b0);
        run_one("mid_carry",  32'h0000FFFF,  32'h00000001,  32'h00010000,  1'b0, 1'b0);
        run_one("add_4000",   32'd4000,      32'd1000,      32'd5000,      1'b0, 1'b0);
        run_one("wrap",       32'hFFFFFFFF,  32'h00000001,  32'h00000000,  1'b1, 1'b0);
        run_one("pos_ovf",    32'h7FFFFFFF,  32'h00000001,  32'h80000000,  1'b0, 1'b1);
        run_one("neg_ovf",    32'h80000000,  32'h80000000,  32'h00000000,  1'b1, 1'b1);

        // Backpressure: two pairs fill the pipe, the third is refused until out_ready rises.
        idle(2);
        rx_q.delete();
        bus.out_ready = 1'b0;
        send(32'd65536,   32'd4, acc);
        send(32'd1265536, 32'd4, acc);
        bus.in_valid = 1'b1;
        bus.input1   = 32'd256;
        bus.input2   = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", bus.in_ready, 0);
            check("bp_out_valid",    bus.out_valid, 1);
            check("bp_out_hold",     bus.out, 32'd65540);
            @(posedge clk);
            #1;
        end
        check("bp_no_emit", rx_q.size(), 0);
        bus.out_ready = 1'b1;
        send(32'd256, 32'd4, acc);
        send(32'd10,  32'd1, acc);
        wait_rx(4);
        idle(6);
        check("bp_count", rx_q.size(), 4);
        exp4 = '{32'd65540, 32'd1265540, 32'd260, 32'd11};
        for (int i = 0; i < 4 && rx_q.size() > 0; i++) begin
            r = rx_q.pop_front();
            check($sformatf("bp_order_%0d", i), r.d, exp4[i]);
        end

        // Back-to-back stream with no bubbles.
        rx_q.delete();
        for (int i = 0; i < 8; i++) begin
            send(32'(i * 3 + 1), 32'(i * 100), acc8[i]);
        end
        wait_rx(8);
        check("b2b_count", rx_q.size(), 8);
        for (int i = 0; i < 8 && rx_q.size() > 0; i++) begin
            r = rx_q.pop_front();
            check($sformatf("b2b_val_%0d", i),  r.d, 32'(i * 103 + 1));
            check($sformatf("b2b_acc_%0d", i),  acc8[i] - acc8[0], i);
            check($sformatf("b2b_cyc_%0d", i),  r.cyc - acc8[0], i + 2);
        end

        // Reset with two pairs in flight, plus a pair offered during the reset cycle.
        idle(2);
        rx_q.delete();
        bus.out_ready = 1'b0;
        send(32'd100, 32'd200, acc);
        send(32'd300, 32'd400, acc);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.input1   = 32'd7;
        bus.input2   = 32'd7;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        run_one("after_rst", 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        idle(6);
        check("rst2_no_stale", rx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the stimulus itself wedges.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
